// File: rtl/mem_bus_ctrl_pkg.sv
// Shared memory-op and exception codes plus the bus FSM state type.
package mem_bus_ctrl_pkg;

  // Memory operation encodings carried on ex_mem_op.
  localparam logic [1:0] MEMOP_NOP = 2'b00;
  localparam logic [1:0] MEMOP_LDW = 2'b01;
  localparam logic [1:0] MEMOP_STW = 2'b10;
  localparam logic [1:0] MEMOP_RSV = 2'b11;

  // ISA exception codes.
  localparam logic [2:0] NO_EXP     = 3'h0;
  localparam logic [2:0] MISS_ALIGN = 3'h4;
  localparam logic [2:0] BUS_ERR    = 3'h7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } bus_state_t;

  // Only LDW and STW touch the bus; the reserved code behaves like NOP.
  function automatic logic is_mem_access(input logic [1:0] op);
    return (op == MEMOP_LDW) || (op == MEMOP_STW);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_mem_reg.sv
// MEM stage output register: loads a new result, is killed to a bubble, or holds.
module mem_reg
  import mem_bus_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        kill,
  input  logic        d_en,
  input  logic [31:0] d_out,
  input  logic [2:0]  d_exp,
  output logic        q_en,
  output logic [31:0] q_out,
  output logic [2:0]  q_exp
);

  // Kill has priority over load so a flush always leaves a bubble behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_en  <= 1'b0;
      q_out <= 32'h0;
      q_exp <= NO_EXP;
    end else if (kill) begin
      q_en  <= 1'b0;
      q_exp <= NO_EXP;
    end else if (load) begin
      q_en  <= d_en;
      q_out <= d_out;
      q_exp <= d_exp;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM stage bus controller: runs one LDW/STW bus transaction at a time
// (request, grant, strobe, wait for ready or timeout) and feeds the result
// into the MEM output register.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_en,
  input  logic [1:0]  ex_mem_op,
  input  logic [31:0] ex_out,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [2:0]  ex_exp_code,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic        busy,
  output logic        mem_en,
  output logic [31:0] mem_out,
  output logic [2:0]  mem_exp_code
);

  // The counter holds completed wait cycles, so the TIMEOUT-th wait cycle is the last.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  bus_state_t  state_q;
  logic [7:0]  wait_cnt_q;
  logic        op_ldw_q;
  logic        flush_pend_q;
  logic        done_q;
  logic [31:0] cap_data_q;
  logic [2:0]  cap_exp_q;

  logic        aligned;
  logic        start;
  logic        rdy_hit;
  logic        to_hit;
  logic        complete;
  logic        load;
  logic        kill;
  logic        res_en;
  logic [31:0] res_out;
  logic [2:0]  res_exp;

  assign aligned  = (ex_out[1:0] == 2'b00);
  // done_q blocks a restart while a finished result waits out a stall.
  assign start    = (state_q == ST_IDLE) && !done_q && ex_en && !flush &&
                    is_mem_access(ex_mem_op) && (ex_exp_code == NO_EXP) && aligned;
  assign rdy_hit  = (state_q == ST_WAIT) && !bus_rdy_;
  assign to_hit   = (state_q == ST_WAIT) && bus_rdy_ && (wait_cnt_q == TO_LAST);
  assign complete = rdy_hit || to_hit;
  assign busy     = start || (state_q == ST_REQ) || ((state_q == ST_WAIT) && !complete);
  assign load     = !stall && !busy;
  // A transaction flushed while in flight still finishes on the bus, but its result is dropped.
  assign kill     = flush || (complete && flush_pend_q);

  // Select the value the MEM register will take: parked bus result, live bus result, or pass-through.
  always_comb begin
    res_en  = ex_en;
    res_out = ex_out;
    res_exp = NO_EXP;
    if (done_q) begin
      res_en  = 1'b1;
      res_out = cap_data_q;
      res_exp = cap_exp_q;
    end else if (complete) begin
      res_en  = 1'b1;
      res_out = (rdy_hit && op_ldw_q) ? bus_rd_data : 32'h0;
      res_exp = rdy_hit ? NO_EXP : BUS_ERR;
    end else if (ex_en) begin
      if (ex_exp_code != NO_EXP) begin
        res_exp = ex_exp_code;
      end else if (is_mem_access(ex_mem_op) && !aligned) begin
        res_exp = MISS_ALIGN;
      end
    end
  end

  // Bus FSM with registered bus outputs, wait counter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 8'h0;
      op_ldw_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      done_q       <= 1'b0;
      cap_data_q   <= 32'h0;
      cap_exp_q    <= NO_EXP;
      bus_req_     <= 1'b1;
      bus_as_      <= 1'b1;
      bus_rw       <= 1'b1;
      bus_addr     <= 30'h0;
      bus_wr_data  <= 32'h0;
    end else begin
      bus_as_ <= 1'b1;
      if (done_q && (load || flush)) begin
        done_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_REQ;
            bus_req_     <= 1'b0;
            op_ldw_q     <= (ex_mem_op == MEMOP_LDW);
            flush_pend_q <= 1'b0;
          end
        end
        ST_REQ: begin
          if (flush) begin
            state_q  <= ST_IDLE;
            bus_req_ <= 1'b1;
          end else if (!bus_grnt_) begin
            state_q     <= ST_WAIT;
            wait_cnt_q  <= 8'h0;
            bus_as_     <= 1'b0;
            bus_rw      <= op_ldw_q;
            bus_addr    <= ex_out[31:2];
            bus_wr_data <= ex_mem_wr_data;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          if (complete) begin
            state_q      <= ST_IDLE;
            bus_req_     <= 1'b1;
            wait_cnt_q   <= 8'h0;
            cap_data_q   <= res_out;
            cap_exp_q    <= res_exp;
            flush_pend_q <= 1'b0;
            done_q       <= !(flush || flush_pend_q) && !load;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          bus_req_ <= 1'b1;
        end
      endcase
    end
  end

  mem_reg u_mem_reg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .kill  (kill),
    .d_en  (res_en),
    .d_out (res_out),
    .d_exp (res_exp),
    .q_en  (mem_en),
    .q_out (mem_out),
    .q_exp (mem_exp_code)
  );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: stimulus pushes expected bus strobes and
// MEM results; monitors pop and compare whenever the DUT strobes or presents mem_en.
module tb_mem_bus_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        ex_en;
  logic [1:0]  ex_mem_op;
  logic [31:0] ex_out;
  logic [31:0] ex_mem_wr_data;
  logic [2:0]  ex_exp_code;
  logic        bus_req_;
  logic        bus_grnt_;
  logic        bus_as_;
  logic        bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;
  logic        busy;
  logic        mem_en;
  logic [31:0] mem_out;
  logic [2:0]  mem_exp_code;

  typedef struct {
    logic [31:0] out;
    logic [2:0]  exp;
    bit          chk_out;
  } res_t;

  typedef struct {
    logic [29:0] addr;
    logic        rw;
    logic [31:0] wdata;
  } bus_t;

  res_t res_q[$];
  bus_t bus_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          rdy_delay = 0;
  logic [31:0] slave_data = 32'h0;
  int          nb;

  mem_bus_ctrl #(.TIMEOUT(255)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .ex_en          (ex_en),
    .ex_mem_op      (ex_mem_op),
    .ex_out         (ex_out),
    .ex_mem_wr_data (ex_mem_wr_data),
    .ex_exp_code    (ex_exp_code),
    .bus_req_       (bus_req_),
    .bus_grnt_      (bus_grnt_),
    .bus_as_        (bus_as_),
    .bus_rw         (bus_rw),
    .bus_addr       (bus_addr),
    .bus_wr_data    (bus_wr_data),
    .bus_rd_data    (bus_rd_data),
    .bus_rdy_       (bus_rdy_),
    .busy           (busy),
    .mem_en         (mem_en),
    .mem_out        (mem_out),
    .mem_exp_code   (mem_exp_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] code);
    ex_en          = 1'b1;
    ex_mem_op      = op;
    ex_out         = addr;
    ex_mem_wr_data = wdata;
    ex_exp_code    = code;
  endtask

  task automatic bubble();
    ex_en          = 1'b0;
    ex_mem_op      = 2'b00;
    ex_out         = 32'h0;
    ex_mem_wr_data = 32'h0;
    ex_exp_code    = 3'h0;
  endtask

  // Counts busy cycles until busy drops, then moves just past the next rising edge.
  task automatic wait_idle(output int n);
    bit seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (busy) n++;
      else seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_bound: busy still 1 after 1000 cycles, required 0");
    end
    step();
  endtask

  task automatic push_res(input logic [31:0] out, input logic [2:0] exp, input bit chk_out);
    res_t r;
    r.out = out;
    r.exp = exp;
    r.chk_out = chk_out;
    res_q.push_back(r);
  endtask

  task automatic push_bus(input logic [29:0] addr, input logic rw, input logic [31:0] wdata);
    bus_t b;
    b.addr = addr;
    b.rw = rw;
    b.wdata = wdata;
    bus_q.push_back(b);
  endtask

  // Bus slave: answers each address strobe with ready after rdy_delay cycles (never if negative).
  initial begin
    int left;
    bit pend;
    bus_rdy_    = 1'b1;
    bus_rd_data = 32'h0;
    pend = 0;
    left = 0;
    forever begin
      @(posedge clk);
      #1;
      bus_rdy_ = 1'b1;
      if (bus_as_ === 1'b0) begin
        pend = (rdy_delay >= 0);
        left = rdy_delay;
      end
      if (pend) begin
        if (left == 0) begin
          bus_rdy_    = 1'b0;
          bus_rd_data = slave_data;
          pend = 0;
        end else begin
          left--;
        end
      end
    end
  end

  // Monitor: compares each bus strobe and each presented MEM result against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_as_ === 1'b0) begin
        if (bus_q.size() == 0) begin
          check("bus_as_unexpected", {31'h0, bus_as_}, 32'h1);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          check("bus_addr", {2'b00, bus_addr}, {2'b00, b.addr});
          check("bus_rw", {31'h0, bus_rw}, {31'h0, b.rw});
          check("bus_wr_data", bus_wr_data, b.wdata);
        end
      end
      if (mem_en === 1'b1) begin
        if (res_q.size() == 0) begin
          check("mem_en_unexpected", {31'h0, mem_en}, 32'h0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("mem_exp_code", {29'h0, mem_exp_code}, {29'h0, r.exp});
          if (r.chk_out) check("mem_out", mem_out, r.out);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'h0, bus_req_}, 32'h1);
    check({tag, "_as"},    {31'h0, bus_as_}, 32'h1);
    check({tag, "_rw"},    {31'h0, bus_rw}, 32'h1);
    check({tag, "_addr"},  {2'b00, bus_addr}, 32'h0);
    check({tag, "_wdata"}, bus_wr_data, 32'h0);
    check({tag, "_en"},    {31'h0, mem_en}, 32'h0);
    check({tag, "_out"},   mem_out, 32'h0);
    check({tag, "_exp"},   {29'h0, mem_exp_code}, 32'h0);
    check({tag, "_busy"},  {31'h0, busy}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    bus_grnt_ = 1'b0;
    bubble();
    repeat (3) step();
    reset = 1'b0;
    check_reset_outputs("rst");

    // LDW 0x100, ready two cycles after the strobe.
    rdy_delay = 2; slave_data = 32'hDEADBEEF;
    push_bus(30'h40, 1'b1, 32'h0);
    push_res(32'hDEADBEEF, 3'h0, 1);
    issue(2'b01, 32'h100, 32'h0, 3'h0);
    wait_idle(nb);
    check("ldw_busy_cycles", nb, 4);
    bubble();
    repeat (2) step();
    check("ldw_req_released", {31'h0, bus_req_}, 32'h1);

    // STW 0x8 with immediate ready.
    rdy_delay = 0;
    push_bus(30'h2, 1'b0, 32'h12345678);
    push_res(32'h0, 3'h0, 1);
    issue(2'b10, 32'h8, 32'h12345678, 3'h0);
    wait_idle(nb);
    check("stw_busy_cycles", nb, 2);
    bubble();
    repeat (2) step();

    // Misaligned LDW.
    push_res(32'h102, 3'h4, 1);
    issue(2'b01, 32'h102, 32'h0, 3'h0);
    wait_idle(nb);
    check("misalign_busy", nb, 0);
    bubble();
    step();
    check("misalign_no_req", {31'h0, bus_req_}, 32'h1);

    // Upstream exception passes through on a store.
    push_res(32'h40, 3'h2, 1);
    issue(2'b10, 32'h40, 32'h55, 3'h2);
    wait_idle(nb);
    check("upexp_busy", nb, 0);
    bubble();
    step();

    // NOP and reserved ops pass ex_out through.
    push_res(32'hCAFEF00D, 3'h0, 1);
    issue(2'b00, 32'hCAFEF00D, 32'h0, 3'h0);
    wait_idle(nb);
    check("nop_busy", nb, 0);
    push_res(32'h10, 3'h0, 1);
    issue(2'b11, 32'h10, 32'h0, 3'h0);
    wait_idle(nb);
    check("rsv_busy", nb, 0);
    bubble();
    step();
    check("rsv_no_req", {31'h0, bus_req_}, 32'h1);

    // LDW completing under stall: result held back until stall drops, no second access.
    rdy_delay = 0; slave_data = 32'hA5A50F0F;
    push_bus(30'h8, 1'b1, 32'h0);
    push_res(32'hA5A50F0F, 3'h0, 1);
    stall = 1'b1;
    issue(2'b01, 32'h20, 32'h0, 3'h0);
    wait_idle(nb);
    check("stall_busy_cycles", nb, 2);
    for (int i = 0; i < 3; i++) begin
      check("stall_hold_req", {31'h0, bus_req_}, 32'h1);
      check("stall_hold_busy", {31'h0, busy}, 32'h0);
      step();
    end
    stall = 1'b0;
    step();
    bubble();
    repeat (2) step();

    // Timeout: ready never comes.
    rdy_delay = -1;
    push_bus(30'h100, 1'b1, 32'h0);
    push_res(32'h0, 3'h7, 0);
    issue(2'b01, 32'h400, 32'h0, 3'h0);
    wait_idle(nb);
    check("timeout_busy_cycles", nb, 256);
    bubble();
    step();
    check("timeout_req_released", {31'h0, bus_req_}, 32'h1);

    // Flush while requesting without grant.
    bus_grnt_ = 1'b1;
    issue(2'b01, 32'h500, 32'h0, 3'h0);
    step();
    check("flreq_req_low", {31'h0, bus_req_}, 32'h0);
    check("flreq_busy", {31'h0, busy}, 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bubble();
    check("flreq_req_released", {31'h0, bus_req_}, 32'h1);
    bus_grnt_ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("flreq_idle_req", {31'h0, bus_req_}, 32'h1);
      check("flreq_idle_busy", {31'h0, busy}, 32'h0);
      step();
    end

    // Flush while waiting: transaction completes, result discarded.
    rdy_delay = 3; slave_data = 32'h11112222;
    push_bus(30'h180, 1'b1, 32'h0);
    issue(2'b01, 32'h600, 32'h0, 3'h0);
    repeat (2) step();
    check("flwait_as_low", {31'h0, bus_as_}, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bubble();
    wait_idle(nb);
    check("flwait_busy_cycles", nb, 2);
    check("flwait_req_released", {31'h0, bus_req_}, 32'h1);
    repeat (3) step();

    // Reset while waiting: back to reset values, later ready ignored.
    rdy_delay = 4; slave_data = 32'h33334444;
    push_bus(30'hC0, 1'b1, 32'h0);
    issue(2'b01, 32'h300, 32'h0, 3'h0);
    repeat (2) step();
    reset = 1'b1;
    bubble();
    step();
    reset = 1'b0;
    check_reset_outputs("rstwait");
    for (int i = 0; i < 5; i++) begin
      check("rstwait_req_idle", {31'h0, bus_req_}, 32'h1);
      check("rstwait_busy_idle", {31'h0, busy}, 32'h0);
      step();
    end

    // Normal access after reset.
    rdy_delay = 1; slave_data = 32'h0BADF00D;
    push_bus(30'h1, 1'b1, 32'h0);
    push_res(32'h0BADF00D, 3'h0, 1);
    issue(2'b01, 32'h4, 32'h0, 3'h0);
    wait_idle(nb);
    check("post_busy_cycles", nb, 3);
    bubble();
    repeat (3) step();

    check("res_queue_drained", res_q.size(), 0);
    check("bus_queue_drained", bus_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max bus wait cycles before bus error.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 stall  in  1  pipeline hold from controller.
REQ-005 flush  in  1  pipeline flush from controller.
REQ-006 ex_en  in  1  EX/MEM entry valid.
REQ-007 ex_mem_op  in  2  00 NOP, 01 LDW, 10 STW, 11 reserved (treated NOP).
REQ-008 ex_out  in  32  byte address for LDW/STW, else result passed through.
REQ-009 ex_mem_wr_data  in  32  store data.
REQ-010 ex_exp_code  in  3  exception already raised upstream.
REQ-011 bus_req_ / bus_grnt_  out / in  1  active-low request/grant.
REQ-012 bus_as_  out  1  active-low address strobe; bus_rw out 1 (1 read, 0 write).
REQ-013 bus_addr out 30 (word address = ex_out[31:2]); bus_wr_data out 32; bus_rd_data in 32; bus_rdy_ in 1 active-low.
REQ-014 busy  out  1  combinational stall request to controller.
REQ-015 mem_en out 1; mem_out out 32; mem_exp_code out 3: registered MEM stage result.

Function
REQ-016 Access starts in IDLE when ex_en=1, op LDW/STW, ex_exp_code=NO_EXP, ex_out[1:0]=00, flush=0.
REQ-017 FSM states: IDLE, REQ, WAIT.
REQ-018 IDLE->REQ on access start; bus_req_=0 from the following cycle.
REQ-019 REQ: hold bus_req_=0; on bus_grnt_=0 drive bus_as_=0, bus_addr, bus_rw, bus_wr_data for exactly one cycle, go WAIT.
REQ-020 WAIT: bus_req_ held 0, bus_as_=1, 8-bit wait counter increments each cycle.
REQ-021 WAIT->IDLE when bus_rdy_=0; bus_rd_data captured that cycle; bus_req_=1 the next cycle.
REQ-022 WAIT->IDLE when counter reaches TIMEOUT with bus_rdy_=1; result exception BUS_ERR (3'h7).
REQ-023 busy=1 in IDLE cycle of access start, all REQ cycles, WAIT cycles without bus_rdy_=0 or timeout; busy=0 otherwise.
REQ-024 Total latency LDW/STW with immediate grant and ready: 3 cycles from start to register load.
REQ-025 Misaligned LDW/STW (ex_out[1:0]!=00): no bus activity, busy=0, mem_exp_code=MISS_ALIGN (3'h4), mem_out=ex_out.
REQ-026 ex_exp_code!=NO_EXP: no bus activity, code passed through unchanged.
REQ-027 NOP/reserved op: no bus activity, mem_out=ex_out.
REQ-028 LDW result: mem_out=captured bus_rd_data; STW result: mem_out=0.
REQ-029 Output register loads when stall=0 and busy=0; holds otherwise.
REQ-030 flush=1 (stall ignored): mem_en=0, mem_exp_code=NO_EXP next cycle.
REQ-031 flush in REQ: abandon, bus_req_=1 next cycle, IDLE.
REQ-032 flush in WAIT: bus transaction completes (rdy or timeout), result discarded (mem_en=0), busy stays 1 until completion.
REQ-033 Ungranted access never asserts bus_as_; at most one outstanding transaction.

Reset
REQ-034 reset: state IDLE, counter 0, bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, mem_en=0, mem_out=0, mem_exp_code=NO_EXP, captured data 0.
REQ-035 reset mid-transaction: return IDLE immediately; bus released next cycle; no result written.

Structure
REQ-036 MEMOP and ISAEXP codes (NO_EXP, MISS_ALIGN, BUS_ERR) live in the shared bus/signal headers.
REQ-037 One sub-module mem_reg holds the output register; FSM and counter in mem_bus_ctrl.

Verification
REQ-038 LDW ex_out=0x100, grant immediate, rdy_ 2 cycles after as_, rd_data=0xDEADBEEF -> bus_addr=0x40, bus_rw=1, mem_out=0xDEADBEEF, busy exactly 4 cycles.
REQ-039 STW ex_out=0x8, wr_data=0x12345678 -> one-cycle as_, bus_rw=0, bus_wr_data=0x12345678, mem_out=0.
REQ-040 LDW ex_out=0x102 -> no req_/as_, busy=0, mem_exp_code=3'h4 next cycle.
REQ-041 LDW, rdy_ never asserted, TIMEOUT=255 -> exit WAIT after 255 wait cycles, mem_exp_code=3'h7, bus_req_ released.
REQ-042 flush in REQ -> req_ released next cycle, no as_; flush in WAIT -> transaction completes, mem_en=0.
REQ-043 reset in WAIT -> all outputs at reset values next cycle, later rdy_ ignored.
